commit_arbiter_n: RTL and testbench
===================================

Name: commit_arbiter_n

Overview:
Parametrised N-channel commit stage between the execution units and the reorder buffer. Each execution channel gets its own commit FIFO. A round-robin arbiter drains one result per cycle into the single ROB write port. When all FIFOs are empty, one incoming result bypasses straight to the ROB; all FIFOs and incoming results also feed operand forwarding to the issue stage.

Parameters:
CHANNELS, 3, number of execution result channels (≥2)
DEPTH, 4, entries per channel FIFO (power of 2, ≥2)
DATA_WIDTH, 32, result width
TAG_WIDTH, 6, ROB tag width
PAYLOAD_WIDTH, 8, opaque per-instruction side info (exception vector, flags) carried to the ROB
FWD_PORTS, 2, number of forwarding lookup ports

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush of all buffered state
stall_i  in  1  ROB cannot accept; no pops, no ROB write
stall_o  out  1  any channel FIFO full (combinational)
valid_i  in  CHANNELS  per-channel result valid
result_i  in  CHANNELS x DATA_WIDTH  per-channel result
reg_dest_i  in  CHANNELS x 5  per-channel destination register
tag_i  in  CHANNELS x TAG_WIDTH  per-channel ROB tag
payload_i  in  CHANNELS x PAYLOAD_WIDTH  per-channel side info
rob_write_o  out  1  ROB write strobe
rob_tag_o  out  TAG_WIDTH  ROB entry tag
rob_result_o  out  DATA_WIDTH  committed result
rob_reg_dest_o  out  5  committed destination
rob_payload_o  out  PAYLOAD_WIDTH  committed side info
buffers_empty_o  out  1  all FIFOs empty
overflow_o  out  1  sticky: valid_i seen on a full channel
fwd_src_i  in  FWD_PORTS x 5  forwarding lookup register addresses
fwd_data_o  out  FWD_PORTS x DATA_WIDTH  forwarded value
fwd_valid_o  out  FWD_PORTS  forwarded value valid

Behaviour:
- Reset (async): FIFOs empty, rr pointer 0, overflow_o 0, forwarding valid bits 0. All outputs 0 except buffers_empty_o=1.
- flush_i (sync, highest priority): empties all FIFOs, sets pointer to 0, clears forwarding bits. Incoming valids that cycle are dropped. rob_write_o=0 in the flush cycle. overflow_o is cleared only by reset.
- Arbitration (stall_i=0, flush_i=0):
  - Scan channels from the pointer, wrapping modulo CHANNELS; the first non-empty FIFO c pops its head to the ROB outputs and rob_write_o=1. Pointer becomes (c+1) mod CHANNELS.
  - If all FIFOs are empty, the first valid_i channel in the same scan order is bypassed: ROB outputs come from its inputs combinationally, with zero latency. That result is not pushed, and the pointer becomes bypassed+1.
  - Nothing pending: rob_write_o=0 and the pointer is held.
- ROB data outputs are 0 whenever rob_write_o=0.
- Push: every valid_i[c] that is not bypassed pushes into FIFO c. Push is also allowed while stall_i=1. Same-cycle push and pop on one FIFO is legal, and the count is unchanged.
- stall_i=1: no pop, no bypass, pointer held, rob_write_o=0.
- stall_o = OR of per-FIFO full. Upstream must hold valid_i[c]=0 while FIFO c is full. A violation drops the data and sets overflow_o.
- FIFO pointers are log2(DEPTH)+1 bits, so full and empty are distinguished by the MSB at wrap-around.
- Forwarding, evaluated independently per port p:
  - fwd_src_i[p]=0: fwd_valid_o[p]=0 and data is 0.
  - Incoming priority: a valid_i[c] with reg_dest_i[c]==fwd_src_i[p] forwards result_i[c]. Upstream guarantees at most one such incoming match.
  - Buffered fallback: otherwise, a buffered entry with its fwd bit set and a matching reg_dest forwards its result.
  - fwd bit lifecycle: set on push. Cleared when any channel presents valid_i with the same reg_dest in a later cycle, including a bypassed result. A popped entry no longer forwards. At most one buffered entry per register therefore has its fwd bit set.
- Reset asserted mid-operation discards all contents immediately.

Test Plan:
- Reset, then single valid on ch1 (tag 5, result 0xAA) with all FIFOs empty → same-cycle rob_write_o=1, tag 5, result 0xAA; pointer=2; FIFO 1 stays empty.
- Valids on ch0/1/2 in one cycle (tags 1, 2, 3), pointer 0 → ch0 bypassed at cycle 0; tags 2 then 3 committed in cycles 1 and 2; buffers_empty_o=1 after cycle 2.
- Hold stall_i=1 while pushing 4 results on ch2 → stall_o=1 after the 4th push. A 5th valid sets overflow_o=1 and is never committed. Release stall → 4 commits in order.
- ch0 pushes x7=0x11 at cycle 0, ch2 pushes x7=0x22 at cycle 1, stall_i=1 → fwd_src_i[1]=7 returns 0x22 with valid. fwd_src_i[0]=0 returns valid=0.
- FIFOs on ch0 and ch1 each holding 2 entries, pointer 1 → commit order ch1, ch0, ch1, ch0 (alternating).
- flush_i with 3 buffered entries plus one incoming valid → the next cycle shows buffers_empty_o=1, rob_write_o=0, pointer 0, and no forwarding hits.

Source files
------------

// File: rtl/commit_arbiter_n.sv
// commit_arbiter_n: per-channel commit FIFOs drained round-robin into a single
// ROB write port. An empty-path bypass gives zero-latency commit. Incoming and
// buffered results are forwarded to the issue stage.
module commit_arbiter_n #(
  parameter int CHANNELS      = 3,
  parameter int DEPTH         = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 6,
  parameter int PAYLOAD_WIDTH = 8,
  parameter int FWD_PORTS     = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              flush_i,
  input  logic                              stall_i,
  output logic                              stall_o,
  input  logic [CHANNELS-1:0]               valid_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0]    result_i,
  input  logic [CHANNELS*5-1:0]             reg_dest_i,
  input  logic [CHANNELS*TAG_WIDTH-1:0]     tag_i,
  input  logic [CHANNELS*PAYLOAD_WIDTH-1:0] payload_i,
  output logic                              rob_write_o,
  output logic [TAG_WIDTH-1:0]              rob_tag_o,
  output logic [DATA_WIDTH-1:0]             rob_result_o,
  output logic [4:0]                        rob_reg_dest_o,
  output logic [PAYLOAD_WIDTH-1:0]          rob_payload_o,
  output logic                              buffers_empty_o,
  output logic                              overflow_o,
  input  logic [FWD_PORTS*5-1:0]            fwd_src_i,
  output logic [FWD_PORTS*DATA_WIDTH-1:0]   fwd_data_o,
  output logic [FWD_PORTS-1:0]              fwd_valid_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [DATA_WIDTH-1:0]    mem_data_q [CHANNELS][DEPTH];
  logic [4:0]               mem_reg_q  [CHANNELS][DEPTH];
  logic [TAG_WIDTH-1:0]     mem_tag_q  [CHANNELS][DEPTH];
  logic [PAYLOAD_WIDTH-1:0] mem_pay_q  [CHANNELS][DEPTH];
  logic [DEPTH-1:0]         fwd_q      [CHANNELS];
  logic [DEPTH-1:0]         fwd_d      [CHANNELS];
  logic [AW:0]              wr_q       [CHANNELS];
  logic [AW:0]              rd_q       [CHANNELS];
  logic [PW-1:0]            ptr_q, ptr_d;
  logic                     overflow_q;

  logic [CHANNELS-1:0] empty, full, push, pop;
  logic                do_pop, do_byp;
  logic [PW-1:0]       sel;

  // Per-channel status; the extra pointer MSB separates full from empty.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_stat
    assign empty[g] = (wr_q[g] == rd_q[g]);
    assign full[g]  = (wr_q[g][AW] != rd_q[g][AW]) &&
                      (wr_q[g][AW-1:0] == rd_q[g][AW-1:0]);
    assign pop[g]   = do_pop && (sel == PW'(g));
    assign push[g]  = valid_i[g] && !flush_i && !full[g] && !(do_byp && sel == PW'(g));
  end

  assign stall_o         = |full;
  assign buffers_empty_o = &empty;
  assign overflow_o      = overflow_q;

  // Round-robin pick: scan in reverse so the channel at the pointer wins last.
  always_comb begin
    int k;
    k      = 0;
    do_pop = 1'b0;
    do_byp = 1'b0;
    sel    = '0;
    ptr_d  = ptr_q;
    if (!flush_i && !stall_i) begin
      for (int i = CHANNELS-1; i >= 0; i--) begin
        k = int'(ptr_q) + i;
        if (k >= CHANNELS) k -= CHANNELS;
        if (!empty[k]) begin
          do_pop = 1'b1;
          sel    = PW'(k);
        end
      end
      if (!do_pop) begin
        for (int i = CHANNELS-1; i >= 0; i--) begin
          k = int'(ptr_q) + i;
          if (k >= CHANNELS) k -= CHANNELS;
          if (valid_i[k]) begin
            do_byp = 1'b1;
            sel    = PW'(k);
          end
        end
      end
      if (do_pop || do_byp) ptr_d = (sel == PW'(CHANNELS-1)) ? '0 : sel + 1'b1;
    end
    if (flush_i) ptr_d = '0;
  end

  // ROB port: FIFO head on pop, raw inputs on bypass, zero otherwise.
  always_comb begin
    rob_write_o    = do_pop | do_byp;
    rob_tag_o      = '0;
    rob_result_o   = '0;
    rob_reg_dest_o = '0;
    rob_payload_o  = '0;
    if (do_pop) begin
      rob_tag_o      = mem_tag_q [sel][rd_q[sel][AW-1:0]];
      rob_result_o   = mem_data_q[sel][rd_q[sel][AW-1:0]];
      rob_reg_dest_o = mem_reg_q [sel][rd_q[sel][AW-1:0]];
      rob_payload_o  = mem_pay_q [sel][rd_q[sel][AW-1:0]];
    end else if (do_byp) begin
      rob_tag_o      = tag_i     [sel*TAG_WIDTH     +: TAG_WIDTH];
      rob_result_o   = result_i  [sel*DATA_WIDTH    +: DATA_WIDTH];
      rob_reg_dest_o = reg_dest_i[sel*5             +: 5];
      rob_payload_o  = payload_i [sel*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    end
  end

  // Forward bits: a newer write to the same register (even bypassed or dropped)
  // retires older entries; popped slots stop forwarding; pushed slots start.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      for (int j = 0; j < DEPTH; j++) begin
        fwd_d[c][j] = fwd_q[c][j];
        for (int v = 0; v < CHANNELS; v++)
          if (valid_i[v] && reg_dest_i[v*5 +: 5] == mem_reg_q[c][j]) fwd_d[c][j] = 1'b0;
        if (pop[c]  && rd_q[c][AW-1:0] == AW'(j)) fwd_d[c][j] = 1'b0;
        if (push[c] && wr_q[c][AW-1:0] == AW'(j)) fwd_d[c][j] = 1'b1;
      end
    end
  end

  // Control state: pointers, forward bits, rr pointer, sticky overflow.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q      <= '0;
      overflow_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        wr_q[c]  <= '0;
        rd_q[c]  <= '0;
        fwd_q[c] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      if (|(valid_i & full)) overflow_q <= 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        if (flush_i) begin
          wr_q[c]  <= '0;
          rd_q[c]  <= '0;
          fwd_q[c] <= '0;
        end else begin
          if (push[c]) wr_q[c] <= wr_q[c] + 1'b1;
          if (pop[c])  rd_q[c] <= rd_q[c] + 1'b1;
          fwd_q[c] <= fwd_d[c];
        end
      end
    end
  end

  // Entry storage; validity is tracked by pointers, so no reset needed.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push[c]) begin
        mem_data_q[c][wr_q[c][AW-1:0]] <= result_i  [c*DATA_WIDTH    +: DATA_WIDTH];
        mem_reg_q [c][wr_q[c][AW-1:0]] <= reg_dest_i[c*5             +: 5];
        mem_tag_q [c][wr_q[c][AW-1:0]] <= tag_i     [c*TAG_WIDTH     +: TAG_WIDTH];
        mem_pay_q [c][wr_q[c][AW-1:0]] <= payload_i [c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      end
    end
  end

  // Forwarding lookup: buffered hit first, an incoming match overrides it.
  always_comb begin
    fwd_valid_o = '0;
    fwd_data_o  = '0;
    for (int p = 0; p < FWD_PORTS; p++) begin
      if (fwd_src_i[p*5 +: 5] != 5'd0) begin
        for (int c = 0; c < CHANNELS; c++)
          for (int j = 0; j < DEPTH; j++)
            if (fwd_q[c][j] && mem_reg_q[c][j] == fwd_src_i[p*5 +: 5]) begin
              fwd_valid_o[p]                         = 1'b1;
              fwd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = mem_data_q[c][j];
            end
        for (int c = 0; c < CHANNELS; c++)
          if (valid_i[c] && reg_dest_i[c*5 +: 5] == fwd_src_i[p*5 +: 5]) begin
            fwd_valid_o[p]                         = 1'b1;
            fwd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = result_i[c*DATA_WIDTH +: DATA_WIDTH];
          end
      end
    end
  end

endmodule

// File: tb/tb_commit_arbiter_n.sv
// Bench for commit_arbiter_n: directed scenarios plus a randomized run against
// a queue-level reference model.
module tb_commit_arbiter_n;
  localparam int C = 3, D = 4, DW = 32, TW = 6, PLW = 8, FP = 2;

  logic clk_i = 1'b0;
  logic rst_n_i, flush_i, stall_i, stall_o;
  logic [C-1:0]     valid_i;
  logic [C*DW-1:0]  result_i;
  logic [C*5-1:0]   reg_dest_i;
  logic [C*TW-1:0]  tag_i;
  logic [C*PLW-1:0] payload_i;
  logic             rob_write_o, buffers_empty_o, overflow_o;
  logic [TW-1:0]    rob_tag_o;
  logic [DW-1:0]    rob_result_o;
  logic [4:0]       rob_reg_dest_o;
  logic [PLW-1:0]   rob_payload_o;
  logic [FP*5-1:0]  fwd_src_i;
  logic [FP*DW-1:0] fwd_data_o;
  logic [FP-1:0]    fwd_valid_o;

  int checks = 0, errs = 0;

  commit_arbiter_n #(.CHANNELS(C), .DEPTH(D), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
                     .PAYLOAD_WIDTH(PLW), .FWD_PORTS(FP)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .stall_i(stall_i),
    .stall_o(stall_o), .valid_i(valid_i), .result_i(result_i),
    .reg_dest_i(reg_dest_i), .tag_i(tag_i), .payload_i(payload_i),
    .rob_write_o(rob_write_o), .rob_tag_o(rob_tag_o), .rob_result_o(rob_result_o),
    .rob_reg_dest_o(rob_reg_dest_o), .rob_payload_o(rob_payload_o),
    .buffers_empty_o(buffers_empty_o), .overflow_o(overflow_o),
    .fwd_src_i(fwd_src_i), .fwd_data_o(fwd_data_o), .fwd_valid_o(fwd_valid_o));

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- reference model: per-channel FIFO lists ----------------
  typedef struct {
    logic [DW-1:0]  res;
    logic [4:0]     rd;
    logic [TW-1:0]  tag;
    logic [PLW-1:0] pay;
    bit             fwd;
  } ent_t;

  ent_t mq [C][D];
  int   cnt [C];
  int   mptr;
  bit   movf;

  bit             e_we, e_byp, e_stall, e_empty;
  int             e_sel;
  logic [TW-1:0]  e_tag;
  logic [DW-1:0]  e_res;
  logic [4:0]     e_rd;
  logic [PLW-1:0] e_pay;
  logic [FP-1:0]  e_fv;
  logic [FP*DW-1:0] e_fd;

  function automatic void model_reset();
    for (int c = 0; c < C; c++) cnt[c] = 0;
    mptr = 0;
    movf = 0;
  endfunction

  function automatic void model_comb();
    int k;
    logic [4:0] src;
    e_we = 0; e_byp = 0; e_sel = -1;
    e_tag = '0; e_res = '0; e_rd = '0; e_pay = '0;
    if (!flush_i && !stall_i) begin
      for (int i = 0; i < C; i++) begin
        k = (mptr + i) % C;
        if (e_sel < 0 && cnt[k] > 0) e_sel = k;
      end
      if (e_sel >= 0) begin
        e_we = 1;
        e_tag = mq[e_sel][0].tag; e_res = mq[e_sel][0].res;
        e_rd  = mq[e_sel][0].rd;  e_pay = mq[e_sel][0].pay;
      end else begin
        for (int i = 0; i < C; i++) begin
          k = (mptr + i) % C;
          if (e_sel < 0 && valid_i[k]) e_sel = k;
        end
        if (e_sel >= 0) begin
          e_we = 1; e_byp = 1;
          e_tag = tag_i[e_sel*TW +: TW];      e_res = result_i[e_sel*DW +: DW];
          e_rd  = reg_dest_i[e_sel*5 +: 5];   e_pay = payload_i[e_sel*PLW +: PLW];
        end
      end
    end
    e_stall = 0; e_empty = 1;
    for (int c = 0; c < C; c++) begin
      if (cnt[c] == D) e_stall = 1;
      if (cnt[c] != 0) e_empty = 0;
    end
    e_fv = '0; e_fd = '0;
    for (int p = 0; p < FP; p++) begin
      src = fwd_src_i[p*5 +: 5];
      if (src != 0) begin
        for (int c = 0; c < C; c++)
          for (int j = 0; j < cnt[c]; j++)
            if (mq[c][j].fwd && mq[c][j].rd == src) begin
              e_fv[p] = 1; e_fd[p*DW +: DW] = mq[c][j].res;
            end
        for (int c = 0; c < C; c++)
          if (valid_i[c] && reg_dest_i[c*5 +: 5] == src) begin
            e_fv[p] = 1; e_fd[p*DW +: DW] = result_i[c*DW +: DW];
          end
      end
    end
  endfunction

  function automatic void model_update();
    int pre [C];
    ent_t e;
    model_comb();
    for (int c = 0; c < C; c++) begin
      pre[c] = cnt[c];
      if (valid_i[c] && cnt[c] == D) movf = 1;
    end
    if (flush_i) begin
      for (int c = 0; c < C; c++) cnt[c] = 0;
      mptr = 0;
      return;
    end
    for (int c = 0; c < C; c++)
      for (int j = 0; j < cnt[c]; j++)
        for (int v = 0; v < C; v++)
          if (valid_i[v] && reg_dest_i[v*5 +: 5] == mq[c][j].rd) mq[c][j].fwd = 0;
    if (e_sel >= 0) mptr = (e_sel + 1) % C;
    if (e_we && !e_byp) begin
      for (int j = 0; j < cnt[e_sel] - 1; j++) mq[e_sel][j] = mq[e_sel][j+1];
      cnt[e_sel]--;
    end
    for (int c = 0; c < C; c++)
      if (valid_i[c] && !(e_byp && e_sel == c) && pre[c] < D) begin
        e.res = result_i[c*DW +: DW]; e.rd = reg_dest_i[c*5 +: 5];
        e.tag = tag_i[c*TW +: TW];    e.pay = payload_i[c*PLW +: PLW];
        e.fwd = 1;
        mq[c][cnt[c]] = e;
        cnt[c]++;
      end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clr_in();
    valid_i = '0; result_i = '0; reg_dest_i = '0; tag_i = '0; payload_i = '0;
  endtask

  task automatic set_ch(input int c, input logic [TW-1:0] tag, input logic [DW-1:0] res,
                        input logic [4:0] rd, input logic [PLW-1:0] pay);
    valid_i[c] = 1'b1;
    tag_i[c*TW +: TW] = tag;
    result_i[c*DW +: DW] = res;
    reg_dest_i[c*5 +: 5] = rd;
    payload_i[c*PLW +: PLW] = pay;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    flush_i = 1'b0; stall_i = 1'b0; fwd_src_i = '0;
    clr_in();
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (rob_write_o !== 1'b0 || rob_tag_o !== '0 || rob_result_o !== '0 ||
        rob_reg_dest_o !== '0 || rob_payload_o !== '0) begin
      errs++;
      $display("FAIL reset_rob: we=%0b tag=%0d res=%h expected all zero", rob_write_o, rob_tag_o, rob_result_o);
    end
    checks++;
    if (buffers_empty_o !== 1'b1 || stall_o !== 1'b0 || overflow_o !== 1'b0 ||
        fwd_valid_o !== '0 || fwd_data_o !== '0) begin
      errs++;
      $display("FAIL reset_status: empty=%0b stall=%0b ovf=%0b fv=%b expected 1/0/0/00",
               buffers_empty_o, stall_o, overflow_o, fwd_valid_o);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    set_ch(1, 6'd5, 32'hAA, 5'd3, 8'h0F);
    #1;
    checks++;
    if (rob_write_o !== 1'b1 || rob_tag_o !== 6'd5 || rob_result_o !== 32'hAA ||
        rob_reg_dest_o !== 5'd3 || rob_payload_o !== 8'h0F) begin
      errs++;
      $display("FAIL bypass_ch1: we=%0b tag=%0d res=%h rd=%0d pay=%h expected 1/5/aa/3/0f",
               rob_write_o, rob_tag_o, rob_result_o, rob_reg_dest_o, rob_payload_o);
    end
    tick();
    clr_in();
    #1;
    checks++;
    if (buffers_empty_o !== 1'b1 || rob_write_o !== 1'b0) begin
      errs++;
      $display("FAIL bypass_not_pushed: empty=%0b we=%0b expected 1/0", buffers_empty_o, rob_write_o);
    end
    set_ch(0, 6'd6, 32'h10, 5'd4, 8'h00);
    set_ch(2, 6'd9, 32'h20, 5'd5, 8'h00);
    #1;
    checks++;
    if (rob_write_o !== 1'b1 || rob_tag_o !== 6'd9) begin
      errs++;
      $display("FAIL bypass_ptr2: we=%0b tag=%0d expected 1/9", rob_write_o, rob_tag_o);
    end
    tick();
    clr_in();
    #1;
    checks++;
    if (rob_write_o !== 1'b1 || rob_tag_o !== 6'd6 || rob_result_o !== 32'h10) begin
      errs++;
      $display("FAIL bypass_follow: we=%0b tag=%0d res=%h expected 1/6/10", rob_write_o, rob_tag_o, rob_result_o);
    end
    tick();
  endtask

  task automatic test_multi();
    do_reset();
    set_ch(0, 6'd1, 32'h101, 5'd1, 8'h1);
    set_ch(1, 6'd2, 32'h102, 5'd2, 8'h2);
    set_ch(2, 6'd3, 32'h103, 5'd3, 8'h3);
    #1;
    checks++;
    if (rob_write_o !== 1'b1 || rob_tag_o !== 6'd1) begin
      errs++;
      $display("FAIL multi_c0: we=%0b tag=%0d expected 1/1", rob_write_o, rob_tag_o);
    end
    tick();
    clr_in();
    #1;
    checks++;
    if (rob_write_o !== 1'b1 || rob_tag_o !== 6'd2 || rob_result_o !== 32'h102 || buffers_empty_o !== 1'b0) begin
      errs++;
      $display("FAIL multi_c1: we=%0b tag=%0d res=%h empty=%0b expected 1/2/102/0",
               rob_write_o, rob_tag_o, rob_result_o, buffers_empty_o);
    end
    tick();
    #1;
    checks++;
    if (rob_write_o !== 1'b1 || rob_tag_o !== 6'd3 || rob_payload_o !== 8'h3) begin
      errs++;
      $display("FAIL multi_c2: we=%0b tag=%0d pay=%h expected 1/3/03", rob_write_o, rob_tag_o, rob_payload_o);
    end
    tick();
    #1;
    checks++;
    if (rob_write_o !== 1'b0 || buffers_empty_o !== 1'b1 || rob_tag_o !== '0) begin
      errs++;
      $display("FAIL multi_done: we=%0b empty=%0b tag=%0d expected 0/1/0", rob_write_o, buffers_empty_o, rob_tag_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clr_in();
      set_ch(2, TW'(10 + i), DW'(100 + i), 5'd8, PLW'(i));
      tick();
    end
    clr_in();
    #1;
    checks++;
    if (stall_o !== 1'b1 || rob_write_o !== 1'b0 || overflow_o !== 1'b0) begin
      errs++;
      $display("FAIL ovf_full: stall_o=%0b we=%0b ovf=%0b expected 1/0/0", stall_o, rob_write_o, overflow_o);
    end
    set_ch(2, 6'd14, 32'd114, 5'd8, 8'h9);
    tick();
    clr_in();
    #1;
    checks++;
    if (overflow_o !== 1'b1 || stall_o !== 1'b1) begin
      errs++;
      $display("FAIL ovf_sticky: ovf=%0b stall_o=%0b expected 1/1", overflow_o, stall_o);
    end
    stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (rob_write_o !== 1'b1 || rob_tag_o !== TW'(10 + i) || rob_result_o !== DW'(100 + i)) begin
        errs++;
        $display("FAIL ovf_drain%0d: we=%0b tag=%0d res=%0d expected 1/%0d/%0d",
                 i, rob_write_o, rob_tag_o, rob_result_o, 10 + i, 100 + i);
      end
      tick();
    end
    #1;
    checks++;
    if (rob_write_o !== 1'b0 || buffers_empty_o !== 1'b1 || overflow_o !== 1'b1 || stall_o !== 1'b0) begin
      errs++;
      $display("FAIL ovf_after: we=%0b empty=%0b ovf=%0b stall_o=%0b expected 0/1/1/0",
               rob_write_o, buffers_empty_o, overflow_o, stall_o);
    end
  endtask

  task automatic test_forward();
    do_reset();
    stall_i = 1'b1;
    set_ch(0, 6'd1, 32'h11, 5'd7, 8'h0);
    tick();
    clr_in();
    set_ch(2, 6'd2, 32'h22, 5'd7, 8'h0);
    fwd_src_i = {5'd7, 5'd0};
    #1;
    checks++;
    if (fwd_valid_o !== 2'b10 || fwd_data_o[DW +: DW] !== 32'h22) begin
      errs++;
      $display("FAIL fwd_incoming: fv=%b d1=%h expected 10/22", fwd_valid_o, fwd_data_o[DW +: DW]);
    end
    tick();
    clr_in();
    #1;
    checks++;
    if (fwd_valid_o !== 2'b10 || fwd_data_o[DW +: DW] !== 32'h22 || fwd_data_o[0 +: DW] !== '0) begin
      errs++;
      $display("FAIL fwd_buffered: fv=%b d1=%h d0=%h expected 10/22/0",
               fwd_valid_o, fwd_data_o[DW +: DW], fwd_data_o[0 +: DW]);
    end
    stall_i = 1'b0;
    #1;
    checks++;
    if (rob_write_o !== 1'b1 || rob_result_o !== 32'h11 || fwd_data_o[DW +: DW] !== 32'h22) begin
      errs++;
      $display("FAIL fwd_pop_old: we=%0b res=%h d1=%h expected 1/11/22", rob_write_o, rob_result_o, fwd_data_o[DW +: DW]);
    end
    tick();
    #1;
    checks++;
    if (rob_write_o !== 1'b1 || rob_result_o !== 32'h22) begin
      errs++;
      $display("FAIL fwd_pop_new: we=%0b res=%h expected 1/22", rob_write_o, rob_result_o);
    end
    tick();
    #1;
    checks++;
    if (fwd_valid_o !== 2'b00 || fwd_data_o !== '0) begin
      errs++;
      $display("FAIL fwd_after_pop: fv=%b d1=%h expected 00/0", fwd_valid_o, fwd_data_o[DW +: DW]);
    end
    fwd_src_i = '0;
  endtask

  task automatic test_alternate();
    logic [TW-1:0] exp_t [4];
    exp_t[0] = 6'd31; exp_t[1] = 6'd21; exp_t[2] = 6'd32; exp_t[3] = 6'd22;
    do_reset();
    set_ch(0, 6'd20, 32'h200, 5'd10, 8'h0);
    tick();
    stall_i = 1'b1;
    clr_in();
    set_ch(0, 6'd21, 32'h210, 5'd11, 8'h0);
    set_ch(1, 6'd31, 32'h310, 5'd12, 8'h0);
    tick();
    clr_in();
    set_ch(0, 6'd22, 32'h220, 5'd13, 8'h0);
    set_ch(1, 6'd32, 32'h320, 5'd14, 8'h0);
    tick();
    clr_in();
    stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (rob_write_o !== 1'b1 || rob_tag_o !== exp_t[i]) begin
        errs++;
        $display("FAIL alt_order%0d: we=%0b tag=%0d expected 1/%0d", i, rob_write_o, rob_tag_o, exp_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_ch(1, 6'd40, 32'h400, 5'd20, 8'h0);
    tick();
    clr_in();
    stall_i = 1'b1;
    set_ch(0, 6'd41, 32'h410, 5'd4, 8'h0);
    set_ch(1, 6'd42, 32'h420, 5'd5, 8'h0);
    tick();
    clr_in();
    set_ch(0, 6'd43, 32'h430, 5'd6, 8'h0);
    tick();
    clr_in();
    stall_i = 1'b0;
    flush_i = 1'b1;
    set_ch(2, 6'd44, 32'h440, 5'd9, 8'h0);
    #1;
    checks++;
    if (rob_write_o !== 1'b0 || rob_tag_o !== '0) begin
      errs++;
      $display("FAIL flush_cycle: we=%0b tag=%0d expected 0/0", rob_write_o, rob_tag_o);
    end
    tick();
    flush_i = 1'b0;
    clr_in();
    fwd_src_i = {5'd9, 5'd4};
    #1;
    checks++;
    if (buffers_empty_o !== 1'b1 || rob_write_o !== 1'b0 || fwd_valid_o !== 2'b00 || stall_o !== 1'b0) begin
      errs++;
      $display("FAIL flush_after: empty=%0b we=%0b fv=%b stall_o=%0b expected 1/0/00/0",
               buffers_empty_o, rob_write_o, fwd_valid_o, stall_o);
    end
    fwd_src_i = '0;
    set_ch(0, 6'd45, 32'h450, 5'd1, 8'h0);
    set_ch(2, 6'd46, 32'h460, 5'd2, 8'h0);
    #1;
    checks++;
    if (rob_write_o !== 1'b1 || rob_tag_o !== 6'd45) begin
      errs++;
      $display("FAIL flush_ptr0: we=%0b tag=%0d expected 1/45", rob_write_o, rob_tag_o);
    end
    tick();
    clr_in();
    #1;
    checks++;
    if (rob_write_o !== 1'b1 || rob_tag_o !== 6'd46) begin
      errs++;
      $display("FAIL flush_next: we=%0b tag=%0d expected 1/46", rob_write_o, rob_tag_o);
    end
    tick();
  endtask

  task automatic test_random();
    int base;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 39) == 0);
      base = $urandom_range(0, 6);
      clr_in();
      for (int c = 0; c < C; c++)
        if ($urandom_range(0, 1) == 1 && cnt[c] < D)
          set_ch(c, TW'($urandom), $urandom, 5'(((base + c) % 7) + 1), PLW'($urandom));
      for (int p = 0; p < FP; p++) fwd_src_i[p*5 +: 5] = 5'($urandom_range(0, 7));
      #1;
      model_comb();
      checks++;
      if (rob_write_o !== e_we || rob_tag_o !== e_tag || rob_result_o !== e_res ||
          rob_reg_dest_o !== e_rd || rob_payload_o !== e_pay) begin
        errs++;
        $display("FAIL rand_rob n=%0d: we=%0b tag=%0d res=%h rd=%0d pay=%h expected %0b/%0d/%h/%0d/%h",
                 n, rob_write_o, rob_tag_o, rob_result_o, rob_reg_dest_o, rob_payload_o,
                 e_we, e_tag, e_res, e_rd, e_pay);
      end
      checks++;
      if (stall_o !== e_stall || buffers_empty_o !== e_empty || overflow_o !== movf) begin
        errs++;
        $display("FAIL rand_status n=%0d: stall_o=%0b empty=%0b ovf=%0b expected %0b/%0b/%0b",
                 n, stall_o, buffers_empty_o, overflow_o, e_stall, e_empty, movf);
      end
      checks++;
      if (fwd_valid_o !== e_fv || fwd_data_o !== e_fd) begin
        errs++;
        $display("FAIL rand_fwd n=%0d: fv=%b fd=%h expected %b/%h", n, fwd_valid_o, fwd_data_o, e_fv, e_fd);
      end
      tick();
    end
    flush_i = 1'b0;
    stall_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_multi();
    test_overflow();
    test_forward();
    test_alternate();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
